instr_queue_register: RTL

Parametrised instruction queue register that replaces the single-entry instruction register between instruction memory and the control unit. It buffers up to DEPTH fetched instruction words in first-word-fall-through order and splits the head word into opcode and address fields. It also exposes a one-entry lookahead opcode for early decode. A valid/ready handshake on both sides and a synchronous flush let the fetch logic run ahead of execution and discard prefetched words on a branch.

---
 rtl/instr_queue_register.sv | 57 +++++
 1 files changed

// File: rtl/instr_queue_register.sv
// instr_queue_register: FWFT instruction queue splitting the head word into opcode/address, with lookahead opcode and flush.
module instr_queue_register #(
  parameter int INSTR_W = 16,
  parameter int OPCODE_W = 4,
  parameter int DEPTH = 4,
  localparam int ADDR_W = INSTR_W - OPCODE_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   address,
  output logic                next_valid,
  output logic [OPCODE_W-1:0] next_opcode,
  output logic [CNT_W-1:0]    count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd, r_wr;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_push, w_pop;
  logic [INSTR_W-1:0] w_head, w_next;
  assign in_ready   = r_cnt != FULL;
  assign out_valid  = r_cnt != '0;
  assign next_valid = r_cnt >= CNT_W'(2);
  assign count      = r_cnt;
  assign w_push     = in_valid && in_ready && !flush;
  assign w_pop      = out_valid && out_ready && !flush;
  assign w_head     = r_mem[r_rd];
  assign w_next     = r_mem[r_rd + PTR_W'(1)];
  always_comb begin
    opcode      = out_valid ? w_head[INSTR_W-1:ADDR_W] : '0;
    address     = out_valid ? w_head[ADDR_W-1:0] : '0;
    next_opcode = next_valid ? w_next[INSTR_W-1:ADDR_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr] <= in_instr;
  end
endmodule
